ship_board: RTL and testbench

//  Own-fleet board for the battleship game. Records ship cells picked during placement
//  and resolves opponent shots (check_in path) into a hit/miss answer for the game FSM.

---
 rtl/ship_board.sv | 165 ++++++++++++++++
 tb/tb_ship_board.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ship_board.sv
// rtl/ship_board.sv - own-fleet battleship board: ship placement, shot resolution, cell query port
module ship_board #(
    parameter int MAX_SHIPS = 9,
    parameter int GRID      = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       place_valid,
    input  logic [7:0] place_pos,
    input  logic       shot_valid,
    input  logic [7:0] shot_pos,
    input  logic       answer_clr,
    input  logic [7:0] query_pos,
    output logic [1:0] query_state,
    output logic [6:0] ship_cnt,
    output logic       placing_done,
    output logic       place_err,
    output logic [1:0] answer,
    output logic       answer_valid,
    output logic       shot_drop,
    output logic       defeat
);

    localparam int         CELLS  = GRID * GRID;
    localparam int         IW     = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [4:0] GRID_W = 5'(GRID);
    localparam logic [7:0] GRID_B = 8'(GRID);
    localparam logic [6:0] LAST   = 7'(MAX_SHIPS - 1);

    localparam logic [1:0] C_EMPTY = 2'b00;
    localparam logic [1:0] C_SHIP  = 2'b01;
    localparam logic [1:0] C_MISS  = 2'b10;
    localparam logic [1:0] C_HIT   = 2'b11;

    typedef enum logic [2:0] {
        PLACE,
        ARMED,
        LOOKUP,
        RESPOND,
        DEFEAT
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] cells [CELLS];
    logic [6:0] hit_cnt;
    logic [7:0] shot_q;

    function automatic logic in_range(input logic [7:0] p);
        return ({1'b0, p[7:4]} < GRID_W) && ({1'b0, p[3:0]} < GRID_W);
    endfunction

    function automatic logic [IW-1:0] cell_idx(input logic [7:0] p);
        return IW'(({4'd0, p[7:4]} * GRID_B) + {4'd0, p[3:0]});
    endfunction

    logic [IW-1:0] p_idx, s_idx, q_idx;
    logic [1:0]    p_cell, s_cell, q_cell;
    logic          is_hit, is_empty, sunk;

    assign p_idx  = cell_idx(place_pos);
    assign s_idx  = cell_idx(shot_q);
    assign q_idx  = cell_idx(query_pos);
    assign p_cell = cells[p_idx];
    assign s_cell = cells[s_idx];
    assign q_cell = cells[q_idx];

    // Lookup result of the latched shot; only meaningful while in LOOKUP
    assign is_hit   = in_range(shot_q) && (s_cell == C_SHIP);
    assign is_empty = in_range(shot_q) && (s_cell == C_EMPTY);
    assign sunk     = is_hit && (hit_cnt == LAST);

    logic place_ok, place_bad, take_shot, drop;

    always_comb begin
        state_nxt = state;
        place_ok  = 1'b0;
        place_bad = 1'b0;
        take_shot = 1'b0;
        drop      = 1'b0;
        unique case (state)
            PLACE: begin
                drop = shot_valid;
                if (place_valid) begin
                    if (in_range(place_pos) && (p_cell == C_EMPTY)) begin
                        place_ok = 1'b1;
                        if (ship_cnt == LAST) state_nxt = ARMED;
                    end else begin
                        place_bad = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (shot_valid) begin
                    // A clear arriving with the shot frees the answer slot in time
                    if (!answer_valid || answer_clr) begin
                        take_shot = 1'b1;
                        state_nxt = LOOKUP;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            LOOKUP: begin
                drop      = shot_valid;
                state_nxt = RESPOND;
            end
            RESPOND: begin
                drop      = shot_valid;
                state_nxt = defeat ? DEFEAT : ARMED;
            end
            DEFEAT: begin
                drop = shot_valid;
            end
            default: state_nxt = PLACE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= PLACE;
            for (int i = 0; i < CELLS; i++) cells[i] <= C_EMPTY;
            ship_cnt     <= '0;
            hit_cnt      <= '0;
            shot_q       <= '0;
            answer       <= 2'b00;
            answer_valid <= 1'b0;
            placing_done <= 1'b0;
            defeat       <= 1'b0;
            place_err    <= 1'b0;
            shot_drop    <= 1'b0;
            query_state  <= 2'b00;
        end else begin
            state       <= state_nxt;
            place_err   <= place_bad;
            shot_drop   <= drop;
            query_state <= in_range(query_pos) ? q_cell : C_EMPTY;

            if (place_ok) begin
                cells[p_idx] <= C_SHIP;
                ship_cnt     <= ship_cnt + 7'd1;
                if (ship_cnt == LAST) placing_done <= 1'b1;
            end

            if (take_shot) shot_q <= shot_pos;

            // The result is registered at the end of LOOKUP so it is visible two cycles after the shot
            if (state == LOOKUP) begin
                answer_valid <= 1'b1;
                if (is_hit) begin
                    cells[s_idx] <= C_HIT;
                    hit_cnt      <= hit_cnt + 7'd1;
                    answer       <= sunk ? 2'b11 : 2'b10;
                    if (sunk) defeat <= 1'b1;
                end else begin
                    answer <= 2'b01;
                    if (is_empty) cells[s_idx] <= C_MISS;
                end
            end else if (answer_clr) begin
                answer       <= 2'b00;
                answer_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ship_board.sv
// tb/tb_ship_board.sv - randomized self-checking bench for ship_board against a game-level model
module tb_ship_board;

    localparam int MAX  = 9;
    localparam int GRID = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       place_valid, shot_valid, answer_clr;
    logic [7:0] place_pos, shot_pos, query_pos;
    logic [1:0] query_state, answer;
    logic [6:0] ship_cnt;
    logic       placing_done, place_err, answer_valid, shot_drop, defeat;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ship_board #(.MAX_SHIPS(MAX), .GRID(GRID)) dut (
        .clk(clk), .rst(rst),
        .place_valid(place_valid), .place_pos(place_pos),
        .shot_valid(shot_valid), .shot_pos(shot_pos),
        .answer_clr(answer_clr), .query_pos(query_pos),
        .query_state(query_state), .ship_cnt(ship_cnt),
        .placing_done(placing_done), .place_err(place_err),
        .answer(answer), .answer_valid(answer_valid),
        .shot_drop(shot_drop), .defeat(defeat)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    function automatic bit on_board(input logic [7:0] p);
        return (int'(p[7:4]) < GRID) && (int'(p[3:0]) < GRID);
    endfunction

    function automatic int at(input logic [7:0] p);
        return int'(p[7:4]) * GRID + int'(p[3:0]);
    endfunction

    // Game-level model: busy counts the cycles a shot spends in flight after acceptance
    logic [1:0] m_cell [GRID*GRID];
    int         m_cnt, m_hits, m_busy, o_busy;
    logic [7:0] m_pend;
    logic [1:0] m_ans, m_q;
    bit         m_done, m_def, m_av, m_perr, m_drop, m_live = 1'b0;
    bit         o_done, o_def, o_av;

    always @(posedge clk) begin
        if (rst) begin
            foreach (m_cell[i]) m_cell[i] = 2'b00;
            m_cnt = 0; m_hits = 0; m_busy = 0; m_pend = '0;
            m_done = 0; m_def = 0; m_av = 0; m_ans = 2'b00;
            m_perr = 0; m_drop = 0; m_q = 2'b00; m_live = 1'b1;
        end else begin
            o_done = m_done; o_def = m_def; o_av = m_av; o_busy = m_busy;
            m_q    = on_board(query_pos) ? m_cell[at(query_pos)] : 2'b00;
            m_perr = 0;
            m_drop = 0;
            if (o_busy == 2) begin
                m_av  = 1;
                m_ans = 2'b01;
                if (on_board(m_pend)) begin
                    if (m_cell[at(m_pend)] == 2'b01) begin
                        m_cell[at(m_pend)] = 2'b11;
                        m_hits++;
                        m_ans = (m_hits == MAX) ? 2'b11 : 2'b10;
                        if (m_hits == MAX) m_def = 1;
                    end else if (m_cell[at(m_pend)] == 2'b00) begin
                        m_cell[at(m_pend)] = 2'b10;
                    end
                end
            end else if (answer_clr) begin
                m_ans = 2'b00;
                m_av  = 0;
            end
            if (o_busy > 0) m_busy = o_busy - 1;
            if (shot_valid) begin
                if (o_done && !o_def && o_busy == 0 && (!o_av || answer_clr)) begin
                    m_pend = shot_pos;
                    m_busy = 2;
                end else begin
                    m_drop = 1;
                end
            end
            if (place_valid && !o_done) begin
                if (on_board(place_pos) && m_cell[at(place_pos)] == 2'b00) begin
                    m_cell[at(place_pos)] = 2'b01;
                    m_cnt++;
                    if (m_cnt == MAX) m_done = 1;
                end else begin
                    m_perr = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("query_state",  8'(query_state),  8'(m_q));
            chk("ship_cnt",     8'(ship_cnt),     8'(m_cnt));
            chk("placing_done", 8'(placing_done), 8'(m_done));
            chk("place_err",    8'(place_err),    8'(m_perr));
            chk("answer",       8'(answer),       8'(m_ans));
            chk("answer_valid", 8'(answer_valid), 8'(m_av));
            chk("shot_drop",    8'(shot_drop),    8'(m_drop));
            chk("defeat",       8'(defeat),       8'(m_def));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input logic [7:0] p);
        place_valid = 1'b1;
        place_pos   = p;
        cyc();
        place_valid = 1'b0;
    endtask

    task automatic shoot(input logic [7:0] p, input bit clr);
        shot_valid = 1'b1;
        shot_pos   = p;
        answer_clr = clr;
        cyc();
        shot_valid = 1'b0;
        answer_clr = 1'b0;
    endtask

    function automatic logic [7:0] rnd_pos();
        if ($urandom % 4 == 0) return 8'($urandom);
        return {4'($urandom_range(0, GRID - 1)), 4'($urandom_range(0, GRID - 1))};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic place_diag();
        for (int i = 0; i < MAX; i++) place({4'(i), 4'(i)});
    endtask

    task automatic sweep();
        for (int r = 0; r < GRID; r++)
            for (int c = 0; c < GRID; c++)
                if (!m_def) begin
                    shoot({4'(r), 4'(c)}, 1'b1);
                    cyc();
                    cyc();
                end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; place_valid = 0; shot_valid = 0; answer_clr = 0;
        place_pos = '0; shot_pos = '0; query_pos = '0;
        cyc(); cyc();
        chk("rst_ship_cnt", 8'(ship_cnt), 8'd0);
        chk("rst_answer",   8'(answer), 8'd0);
        chk("rst_flags",    {3'd0, placing_done, place_err, answer_valid, shot_drop, defeat}, 8'd0);
        chk("rst_query",    8'(query_state), 8'd0);
        rst = 1'b0;

        // Duplicate and off-board placements are rejected
        place(8'h23);
        chk("dup_cnt1", 8'(ship_cnt), 8'd1);
        chk("dup_err1", 8'(place_err), 8'd0);
        place(8'h23);
        chk("dup_err2", 8'(place_err), 8'd1);
        place(8'hA0);
        chk("oor_err", 8'(place_err), 8'd1);
        chk("oor_cnt", 8'(ship_cnt), 8'd1);
        cyc();
        chk("err_pulse_end", 8'(place_err), 8'd0);

        do_reset();
        place_diag();
        chk("diag_cnt",  8'(ship_cnt), 8'd9);
        chk("diag_done", 8'(placing_done), 8'd1);
        place(8'h55);
        chk("armed_place_noerr", 8'(place_err), 8'd0);
        chk("armed_place_cnt",   8'(ship_cnt), 8'd9);

        shoot(8'h11, 1'b0);
        cyc();
        chk("hit_answer", 8'(answer), 8'd2);
        chk("hit_valid",  8'(answer_valid), 8'd1);
        answer_clr = 1'b1; cyc(); answer_clr = 1'b0;
        chk("clr_valid", 8'(answer_valid), 8'd0);
        shoot(8'h11, 1'b0);
        cyc();
        chk("repeat_answer", 8'(answer), 8'd1);
        query_pos = 8'h11; cyc();
        chk("query_hit", 8'(query_state), 8'd3);
        answer_clr = 1'b1; cyc(); answer_clr = 1'b0;
        shoot(8'h09, 1'b0);
        cyc();
        chk("miss_answer", 8'(answer), 8'd1);
        query_pos = 8'h09; cyc();
        chk("query_miss", 8'(query_state), 8'd2);
        shoot(8'h33, 1'b0);
        chk("busy_drop", 8'(shot_drop), 8'd1);
        chk("busy_keep", 8'(answer), 8'd1);
        query_pos = 8'h33; cyc();
        chk("query_untouched", 8'(query_state), 8'd1);

        // Random play that never touches the last ship cell, so the sweep ends on it
        for (int k = 0; k < 400; k++) begin
            shot_valid  = ($urandom % 3 == 0);
            shot_pos    = rnd_pos();
            if (shot_pos == 8'h88) shot_pos = 8'h87;
            answer_clr  = ($urandom % 4 == 0);
            place_valid = ($urandom % 8 == 0);
            place_pos   = rnd_pos();
            query_pos   = rnd_pos();
            cyc();
        end
        shot_valid = 0; answer_clr = 0; place_valid = 0;
        cyc(); cyc(); cyc();
        sweep();
        chk("sunk_answer", 8'(answer), 8'd3);
        chk("sunk_defeat", 8'(defeat), 8'd1);
        shoot(8'h00, 1'b0);
        chk("defeat_drop", 8'(shot_drop), 8'd1);
        chk("defeat_hold", 8'(answer), 8'd3);
        answer_clr = 1'b1; cyc(); answer_clr = 1'b0;
        chk("defeat_clr", 8'(answer), 8'd0);
        chk("defeat_stay", 8'(defeat), 8'd1);

        // Fully random game
        do_reset();
        for (int k = 0; k < 3000 && !m_done; k++) begin
            place_valid = ($urandom % 2 == 0);
            place_pos   = rnd_pos();
            shot_valid  = ($urandom % 5 == 0);
            shot_pos    = rnd_pos();
            answer_clr  = ($urandom % 4 == 0);
            query_pos   = rnd_pos();
            cyc();
        end
        place_valid = 0;
        cyc();
        chk("rand_done", 8'(placing_done), 8'd1);
        for (int k = 0; k < 300; k++) begin
            shot_valid  = ($urandom % 2 == 0);
            shot_pos    = rnd_pos();
            answer_clr  = ($urandom % 3 == 0);
            place_valid = ($urandom % 6 == 0);
            place_pos   = rnd_pos();
            query_pos   = rnd_pos();
            cyc();
        end
        shot_valid = 0; answer_clr = 0; place_valid = 0;
        cyc(); cyc(); cyc();
        sweep();
        cyc();
        chk("rand_defeat", 8'(defeat), 8'd1);

        // Reset while a response is being presented
        do_reset();
        place_diag();
        shoot(8'h22, 1'b0);
        cyc();
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("mid_rst_answer", 8'(answer), 8'd0);
        chk("mid_rst_cnt",    8'(ship_cnt), 8'd0);
        chk("mid_rst_flags",  {3'd0, placing_done, place_err, answer_valid, shot_drop, defeat}, 8'd0);
        query_pos = 8'h22; cyc();
        chk("mid_rst_query", 8'(query_state), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
